// File: rtl/pic_pkg.sv
// Shared constants for the programmable interrupt controller: register
// addresses and default channel/vector widths.
package pic_pkg;

    localparam int NCH_DEFAULT = 8;
    localparam int VW_DEFAULT  = 4;

    // Register map decoded from the 2-bit register select.
    typedef enum logic [1:0] {
        PIC_MASK = 2'd0,
        PIC_MODE = 2'd1,
        PIC_PEND = 2'd2,
        PIC_ISR  = 2'd3
    } pic_reg_e;

endpackage

// File: rtl/pic_prio.sv
// Fixed-priority encoder: reports the lowest set index of a vector.
// Bit 0 has the highest priority.
module pic_prio #(
    parameter int N = 8,
    parameter int W = 4
) (
    input  logic [N-1:0] vec,
    output logic [W-1:0] idx,
    output logic         valid
);

    // Scan from the top down so the lowest set bit is the last one written.
    always_comb begin
        // NOTE: every output of a combinational block gets a default first,
        // otherwise a path that skips the assignment infers a latch.
        idx   = '0;
        valid = 1'b0;
        for (int i = N - 1; i >= 0; i--) begin
            if (vec[i]) begin
                idx   = W'(i);
                valid = 1'b1;
            end
        end
    end

endmodule

// File: rtl/pic.sv
// Programmable interrupt controller: synchronizes device lines, keeps
// pending/in-service state per channel and raises a registered request
// with the vector of the highest-priority eligible channel.
module pic
    import pic_pkg::*;
#(
    parameter int NCH = NCH_DEFAULT,
    parameter int VW  = VW_DEFAULT
) (
    input  logic           CLK0,
    input  logic           RST,
    input  logic [NCH-1:0] IRQ,
    input  logic           PIC_We,
    input  logic [1:0]     PIC_A,
    input  logic [15:0]    PIC_Wd,
    output logic [15:0]    PIC_Rd,
    input  logic           I_I,
    output logic           PIC_I,
    output logic [VW-1:0]  PIC_V
);

    logic [NCH-1:0] sync1, sync2, sync_d;
    logic [NCH-1:0] mask_q, mode_q, pend_q, isr_q;
    logic [NCH-1:0] pend_next, isr_next;
    logic [NCH-1:0] wd, req, rise, ack_onehot, eoi_onehot, pend_clr;
    logic [VW-1:0]  h_idx, s_idx;
    logic           h_valid, s_valid;
    logic           we_mask, we_mode, we_pend, we_isr;
    logic           ack, irq_next;

    // Data bits above the channel count carry no meaning and are dropped.
    logic           wd_unused;
    assign wd_unused = ^PIC_Wd;
    assign wd        = PIC_Wd[NCH-1:0];

    assign we_mask = PIC_We && (PIC_A == PIC_MASK);
    assign we_mode = PIC_We && (PIC_A == PIC_MODE);
    assign we_pend = PIC_We && (PIC_A == PIC_PEND);
    assign we_isr  = PIC_We && (PIC_A == PIC_ISR);

    // An acknowledge only counts while a request is actually outstanding.
    assign ack  = I_I && PIC_I;
    assign req  = pend_q & ~mask_q;
    assign rise = sync2 & ~sync_d;

    pic_prio #(.N(NCH), .W(VW)) u_req_prio (
        .vec   (req),
        .idx   (h_idx),
        .valid (h_valid)
    );

    pic_prio #(.N(NCH), .W(VW)) u_isr_prio (
        .vec   (isr_q),
        .idx   (s_idx),
        .valid (s_valid)
    );

    // One-hot of the channel being acknowledged this cycle.
    always_comb begin
        ack_onehot = '0;
        for (int i = 0; i < NCH; i++) begin
            ack_onehot[i] = ack && (PIC_V == VW'(i));
        end
    end

    // Lowest in-service bit; zero when nothing is in service, so an EOI
    // with an empty ISR falls out as a no-op.
    assign eoi_onehot = isr_q & (~isr_q + NCH'(1));

    assign pend_clr = (we_pend ? wd : '0) | ack_onehot;

    // Edge channels latch rising edges until cleared (a new edge beats a
    // clear); level channels simply follow the synchronized line.
    always_comb begin
        pend_next = '0;
        for (int i = 0; i < NCH; i++) begin
            if (mode_q[i]) begin
                pend_next[i] = rise[i] | (pend_q[i] & ~pend_clr[i]);
            end else begin
                pend_next[i] = sync2[i];
            end
        end
    end

    // EOI retires the current (lowest) in-service bit before the new
    // acknowledge is recorded.
    assign isr_next = (we_isr ? (isr_q & ~eoi_onehot) : isr_q) | ack_onehot;

    // Request when something unmasked is pending and it outranks whatever
    // is in service; an acknowledge always drops the request for a cycle.
    assign irq_next = !ack && h_valid && (!s_valid || (h_idx < s_idx));

    // Two-flop synchronizer plus one delayed copy for edge detection.
    always_ff @(posedge CLK0) begin
        // NOTE: sequential state uses non-blocking assignments so each flop
        // samples the pre-edge value of its neighbour.
        if (RST) begin
            sync1  <= '0;
            sync2  <= '0;
            sync_d <= '0;
        end else begin
            sync1  <= IRQ;
            sync2  <= sync1;
            sync_d <= sync2;
        end
    end

    // Controller register file.
    always_ff @(posedge CLK0) begin
        if (RST) begin
            mask_q <= '1;
            mode_q <= '0;
            pend_q <= '0;
            isr_q  <= '0;
        end else begin
            if (we_mask) mask_q <= wd;
            if (we_mode) mode_q <= wd;
            pend_q <= pend_next;
            isr_q  <= isr_next;
        end
    end

    // Registered request and vector towards execute control.
    always_ff @(posedge CLK0) begin
        if (RST) begin
            PIC_I <= 1'b0;
            PIC_V <= '0;
        end else begin
            PIC_I <= irq_next;
            if (irq_next) PIC_V <= h_idx;
        end
    end

    // Combinational register read, zero-extended to the bus width.
    always_comb begin
        PIC_Rd = '0;
        case (PIC_A)
            PIC_MASK: PIC_Rd = 16'(mask_q);
            PIC_MODE: PIC_Rd = 16'(mode_q);
            PIC_PEND: PIC_Rd = 16'(pend_q);
            PIC_ISR:  PIC_Rd = 16'(isr_q);
            default:  PIC_Rd = '0;
        endcase
    end

endmodule

// File: tb/tb_pic.sv
// Self-checking bench for pic: directed scenarios plus randomized traffic,
// all compared against a behavioural model of the controller rules.
module tb_pic;
    import pic_pkg::*;

    logic        CLK0;
    logic        RST;
    logic [7:0]  IRQ;
    logic        PIC_We;
    logic [1:0]  PIC_A;
    logic [15:0] PIC_Wd;
    logic [15:0] PIC_Rd;
    logic        I_I;
    logic        PIC_I;
    logic [3:0]  PIC_V;

    int tests_run = 0;
    int tests_failed = 0;

    pic #(.NCH(8), .VW(4)) dut (
        .CLK0   (CLK0),
        .RST    (RST),
        .IRQ    (IRQ),
        .PIC_We (PIC_We),
        .PIC_A  (PIC_A),
        .PIC_Wd (PIC_Wd),
        .PIC_Rd (PIC_Rd),
        .I_I    (I_I),
        .PIC_I  (PIC_I),
        .PIC_V  (PIC_V)
    );

    initial CLK0 = 1'b0;
    always #10 CLK0 = ~CLK0;

    // Reference model state: IRQ samples by age (0 = newest), registers.
    bit [7:0] hist0, hist1, hist2;
    bit [7:0] m_mask, m_mode, m_pend, m_isr;
    bit       m_pic_i;
    bit [3:0] m_pic_v;

    task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int lowest(bit [7:0] v);
        for (int i = 0; i < 8; i++) if (v[i]) return i;
        return -1;
    endfunction

    function automatic bit [15:0] reg_exp(int r);
        case (r)
            0:       return {8'h00, m_mask};
            1:       return {8'h00, m_mode};
            2:       return {8'h00, m_pend};
            default: return {8'h00, m_isr};
        endcase
    endfunction

    // Apply one clock edge of controller rules to the model.
    task automatic model_step(bit rst, bit we, bit [1:0] a, bit [15:0] wd, bit ii, bit [7:0] irq);
        bit [7:0] n_pend;
        bit [7:0] n_isr;
        bit       ack;
        int       h, s;
        if (rst) begin
            hist0 = 0; hist1 = 0; hist2 = 0;
            m_mask = 8'hFF; m_mode = 0; m_pend = 0; m_isr = 0;
            m_pic_i = 0; m_pic_v = 0;
            return;
        end
        h   = lowest(m_pend & ~m_mask);
        s   = lowest(m_isr);
        ack = ii && m_pic_i;
        for (int ch = 0; ch < 8; ch++) begin
            if (m_mode[ch]) begin
                if (hist1[ch] && !hist2[ch]) n_pend[ch] = 1'b1;
                else if ((we && a == 2 && wd[ch]) || (ack && m_pic_v == ch)) n_pend[ch] = 1'b0;
                else n_pend[ch] = m_pend[ch];
            end else begin
                n_pend[ch] = hist1[ch];
            end
        end
        n_isr = m_isr;
        if (we && a == 3 && s >= 0) n_isr[s] = 1'b0;
        if (ack) n_isr[m_pic_v] = 1'b1;
        m_pic_i = !ack && (h >= 0) && (s < 0 || h < s);
        if (m_pic_i) m_pic_v = 4'(h);
        if (we && a == 0) m_mask = wd[7:0];
        if (we && a == 1) m_mode = wd[7:0];
        m_pend = n_pend;
        m_isr  = n_isr;
        hist2 = hist1; hist1 = hist0; hist0 = irq;
    endtask

    // Drive one cycle of inputs, step the model on the edge, then compare
    // the outputs and every register.
    task automatic cycle(bit rst, bit we, bit [1:0] a, bit [15:0] wd, bit ii, bit [7:0] irq);
        string names[4] = '{"rd_mask", "rd_mode", "rd_pend", "rd_isr"};
        RST = rst; PIC_We = we; PIC_A = a; PIC_Wd = wd; I_I = ii; IRQ = irq;
        @(posedge CLK0);
        model_step(rst, we, a, wd, ii, irq);
        #1;
        PIC_We = 1'b0;
        I_I    = 1'b0;
        check("pic_i", PIC_I, m_pic_i);
        check("pic_v", PIC_V, m_pic_v);
        for (int r = 0; r < 4; r++) begin
            PIC_A = 2'(r);
            #1;
            check(names[r], PIC_Rd, reg_exp(r));
        end
    endtask

    task automatic idle(int n, bit [7:0] irq);
        for (int i = 0; i < n; i++) cycle(0, 0, 2'd0, 16'h0, 0, irq);
    endtask

    task automatic wr(bit [1:0] a, bit [15:0] d, bit [7:0] irq);
        cycle(0, 1, a, d, 0, irq);
    endtask

    task automatic ack_cycle(bit [7:0] irq);
        cycle(0, 0, 2'd0, 16'h0, 1, irq);
    endtask

    task automatic do_reset(bit [7:0] irq);
        cycle(1, 0, 2'd0, 16'h0, 0, irq);
        cycle(1, 0, 2'd0, 16'h0, 0, irq);
    endtask

    task automatic peek(bit [1:0] a, output logic [15:0] v);
        PIC_A = a;
        #1;
        v = PIC_Rd;
    endtask

    initial begin
        logic [15:0] v;
        bit [7:0]    lvl;
        RST = 1'b1; IRQ = '0; PIC_We = 1'b0; PIC_A = '0; PIC_Wd = '0; I_I = 1'b0;

        // Everything masked after reset: no request despite all lines high.
        do_reset(8'h00);
        idle(6, 8'hFF);
        check("masked_pic_i", PIC_I, 0);
        peek(PIC_MASK, v); check("reset_mask", v, 16'h00FF);

        // Single edge pulse on channel 0, then acknowledge.
        do_reset(8'h00);
        wr(PIC_MASK, 16'h00FE, 8'h00);
        wr(PIC_MODE, 16'h0001, 8'h00);
        idle(2, 8'h00);
        idle(1, 8'h01);
        idle(2, 8'h00);
        check("edge_not_yet", PIC_I, 0);
        idle(1, 8'h00);
        check("edge_pic_i", PIC_I, 1);
        check("edge_pic_v", PIC_V, 0);
        ack_cycle(8'h00);
        check("ack_drop", PIC_I, 0);
        peek(PIC_ISR, v);  check("ack_isr", v, 16'h0001);
        peek(PIC_PEND, v); check("ack_pend", v, 16'h0000);
        wr(PIC_ISR, 16'h0000, 8'h00);
        peek(PIC_ISR, v);  check("eoi_isr", v, 16'h0000);

        // Channel 3 in service, channel 1 nests, then EOI ordering.
        do_reset(8'h00);
        wr(PIC_MASK, 16'h0000, 8'h08);
        idle(4, 8'h08);
        check("ch3_pic_v", PIC_V, 3);
        ack_cycle(8'h08);
        idle(2, 8'h08);
        check("equal_waits", PIC_I, 0);
        idle(4, 8'h0A);
        check("nest_pic_i", PIC_I, 1);
        check("nest_pic_v", PIC_V, 1);
        ack_cycle(8'h0A);
        peek(PIC_ISR, v); check("isr_0a", v, 16'h000A);
        idle(4, 8'h00);
        wr(PIC_ISR, 16'hFFFF, 8'h00);
        peek(PIC_ISR, v); check("eoi_0a", v, 16'h0008);
        idle(4, 8'h04);
        check("ch2_pic_v", PIC_V, 2);
        cycle(0, 1, PIC_ISR, 16'h0, 1, 8'h04);
        peek(PIC_ISR, v); check("eoi_plus_ack", v, 16'h0004);
        idle(4, 8'h00);
        wr(PIC_ISR, 16'h0, 8'h00);

        // Lower-priority channel 5 waits behind channel 3 until EOI.
        do_reset(8'h00);
        wr(PIC_MASK, 16'h0000, 8'h08);
        idle(4, 8'h08);
        ack_cycle(8'h08);
        idle(6, 8'h28);
        check("lower_waits", PIC_I, 0);
        idle(4, 8'h20);
        check("lower_still_waits", PIC_I, 0);
        wr(PIC_ISR, 16'h0, 8'h20);
        idle(1, 8'h20);
        check("after_eoi_pic_i", PIC_I, 1);
        check("after_eoi_pic_v", PIC_V, 5);

        // Edge set beats PEND clear in the same cycle.
        do_reset(8'h00);
        wr(PIC_MODE, 16'h0010, 8'h00);
        idle(4, 8'h10);
        peek(PIC_PEND, v); check("edge_pend_set", v, 16'h0010);
        idle(4, 8'h00);
        peek(PIC_PEND, v); check("edge_pend_held", v, 16'h0010);
        idle(2, 8'h10);
        wr(PIC_PEND, 16'h0010, 8'h10);
        peek(PIC_PEND, v); check("set_wins", v, 16'h0010);
        wr(PIC_PEND, 16'h0010, 8'h10);
        peek(PIC_PEND, v); check("clear_pend", v, 16'h0000);

        // Reset in the middle of service.
        do_reset(8'h00);
        wr(PIC_MASK, 16'h0000, 8'h02);
        idle(4, 8'h02);
        ack_cycle(8'h02);
        idle(4, 8'h03);
        check("pre_rst_pic_i", PIC_I, 1);
        peek(PIC_ISR, v); check("pre_rst_isr", v, 16'h0002);
        cycle(1, 0, 2'd0, 16'h0, 0, 8'h03);
        check("rst_pic_i", PIC_I, 0);
        peek(PIC_ISR, v);  check("rst_isr", v, 16'h0000);
        peek(PIC_MASK, v); check("rst_mask", v, 16'h00FF);
        wr(PIC_MASK, 16'h0000, 8'h03);
        idle(1, 8'h03);
        check("quiet_after_rst", PIC_I, 0);
        idle(3, 8'h03);

        // Randomized traffic against the model.
        lvl = 8'h00;
        do_reset(lvl);
        for (int n = 0; n < 800; n++) begin
            bit        rst, we, ii;
            bit [1:0]  a;
            bit [15:0] wd;
            if ($urandom_range(0, 2) == 0) lvl[$urandom_range(0, 7)] ^= 1'b1;
            rst = ($urandom_range(0, 199) == 0);
            we  = ($urandom_range(0, 3) == 0);
            a   = 2'($urandom_range(0, 3));
            wd  = 16'($urandom);
            ii  = ($urandom_range(0, 2) == 0);
            cycle(rst, we, a, wd, ii, lvl);
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
